// File: rtl/encoder_seq.sv
// encoder_seq: multi-hot vector to index stream; ENCODER_SEQ_MSB_FIRST_EN scans highest bit first
module encoder_seq #(
  parameter int BIN_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2**BIN_WIDTH-1:0]  enc_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BIN_WIDTH-1:0]     bin_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_zero
);
  localparam int N = 2**BIN_WIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  logic [0:0] state;
  logic [N-1:0] pending, src;
  logic [BIN_WIDTH-1:0] idx;
  logic accept, single;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  // search source is the fresh vector on accept, else pending minus the beat being emitted
  assign src = in_ready ? enc_in : pending & ~(N'(1) << bin_out);
  assign single = (src & (src - N'(1))) == '0;
  always_comb begin
    idx = '0;
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    for (int i = 0; i < N; i++) idx = src[i] ? BIN_WIDTH'(i) : idx;
`else
    for (int i = N-1; i >= 0; i--) idx = src[i] ? BIN_WIDTH'(i) : idx;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      bin_out <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_zero <= 1'b0;
    end else if (accept) begin
      state <= EMIT;
      pending <= enc_in;
      bin_out <= idx;
      out_valid <= 1'b1;
      out_last <= single;
      out_zero <= enc_in == '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state <= IDLE;
        out_valid <= 1'b0;
        out_last <= 1'b0;
        out_zero <= 1'b0;
      end else begin
        pending <= src;
        bin_out <= idx;
        out_last <= single;
      end
    end
  end
endmodule

// File: tb/tb_encoder_seq.sv
// tb_encoder_seq: directed vector table plus backpressure and mid-stream reset sequences
module tb_encoder_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] enc_in = '0;
  logic in_ready, out_valid, out_last, out_zero;
  logic [3:0] bin_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic [15:0] enc;
    int n;
    logic [63:0] beats;
    bit zero;
  } vec_t;
  vec_t tbl[7];

  encoder_seq #(.BIN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enc_in(enc_in), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [15:0] e, input int n, input logic [63:0] b, input bit z);
    logic [3:0] exp_idx;
    chk("pre_in_ready", 32'(in_ready), 1);
    enc_in = e;
    in_valid = 1;
    out_ready = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < n; k++) begin
      exp_idx = b[4*k +: 4];
      chk($sformatf("valid_%h_%0d", e, k), 32'(out_valid), 1);
      chk($sformatf("bin_%h_%0d", e, k), 32'(bin_out), 32'(exp_idx));
      chk($sformatf("last_%h_%0d", e, k), 32'(out_last), 32'(k == n-1));
      chk($sformatf("zero_%h_%0d", e, k), 32'(out_zero), 32'(z));
      chk($sformatf("in_ready_low_%h_%0d", e, k), 32'(in_ready), 0);
      tick();
    end
    chk($sformatf("done_valid_%h", e), 32'(out_valid), 0);
  endtask

  initial begin
    tbl[0] = '{16'h0008, 1, 64'h3, 0};
    tbl[1] = '{16'h0000, 1, 64'h0, 1};
    tbl[2] = '{16'h8000, 1, 64'hF, 0};
    tbl[3] = '{16'h0010, 1, 64'h4, 0};
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    tbl[4] = '{16'h8421, 4, 64'h05AF, 0};
    tbl[5] = '{16'hFFFF, 16, 64'h0123456789ABCDEF, 0};
    tbl[6] = '{16'h8001, 2, 64'h0F, 0};
`else
    tbl[4] = '{16'h8421, 4, 64'hFA50, 0};
    tbl[5] = '{16'hFFFF, 16, 64'hFEDCBA9876543210, 0};
    tbl[6] = '{16'h8001, 2, 64'hF0, 0};
`endif
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_zero", 32'(out_zero), 0);
    rst_n = 1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    // back-to-back vectors: each accept follows the previous last beat by one cycle
    for (int i = 0; i < 7; i++) run_vec(tbl[i].enc, tbl[i].n, tbl[i].beats, tbl[i].zero);

    // backpressure on 0x0006 with ignored in_valid pulses
    out_ready = 0;
    enc_in = 16'h0006;
    in_valid = 1;
    tick();
    enc_in = 16'h0080;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(out_valid), 1);
`ifdef ENCODER_SEQ_MSB_FIRST_EN
      chk("bp_bin", 32'(bin_out), 2);
`else
      chk("bp_bin", 32'(bin_out), 1);
`endif
      chk("bp_last", 32'(out_last), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    chk("bp_beat0", 32'(bin_out), 2);
`else
    chk("bp_beat0", 32'(bin_out), 1);
`endif
    chk("bp_last0", 32'(out_last), 0);
    tick();
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    chk("bp_beat1", 32'(bin_out), 1);
`else
    chk("bp_beat1", 32'(bin_out), 2);
`endif
    chk("bp_last1", 32'(out_last), 1);
    chk("bp_valid1", 32'(out_valid), 1);
    tick();
    chk("bp_no_extra", 32'(out_valid), 0);
    chk("bp_idle", 32'(in_ready), 1);

    // mid-stream reset on 0xFFFF after two handshakes
    enc_in = 16'hFFFF;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("mr_mid_valid", 32'(out_valid), 1);
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    chk("mr_mid_bin", 32'(bin_out), 13);
`else
    chk("mr_mid_bin", 32'(bin_out), 2);
`endif
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_bin", 32'(bin_out), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    tick();
    chk("mr_quiet", 32'(out_valid), 0);
    run_vec(16'h0010, 1, 64'h4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/encoder_seq.md
Name: encoder_seq

Overview:
- Sequential encoder: the inverse direction of the team's parameterized decoder. It converts a 2**BIN_WIDTH-bit encoded (multi-hot) vector into a stream of BIN_WIDTH-bit binary indices.
- It emits one index per set bit, lowest index first by default, over a valid/ready output handshake.
- It sits between request/flag vectors (interrupt pending, arbiter grants, decoded selects) and logic that consumes binary indices one at a time.

Parameters:
- BIN_WIDTH, 4, binary index width; the encoded vector is 2**BIN_WIDTH bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enc_in  input  2**BIN_WIDTH  encoded input vector; sampled only on accept.
- in_valid  input  1  enc_in is valid.
- in_ready  output  1  block can accept a new vector.
- bin_out  output  BIN_WIDTH  binary index of the current set bit.
- out_valid  output  1  bin_out is valid.
- out_ready  input  1  downstream accepts bin_out.
- out_last  output  1  current beat is the final beat for this vector.
- out_zero  output  1  accepted vector was all-zero; bin_out=0 on that beat.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, pending=0, bin_out=0, out_valid=0, out_last=0, out_zero=0. in_ready=1 from the first edge after rst_n returns high.
- Reset is synchronous: rst_n has no effect between edges. Mid-operation reset discards all remaining beats; no partial output follows.
- All outputs are registered, except in_ready = (state==IDLE).
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept: in_valid & in_ready at an edge. pending <= enc_in, state <= EMIT.
  - out_valid=1 on the next cycle, so latency from accept edge to first valid beat is 1 cycle.
- State EMIT:
  - in_ready=0.
  - bin_out = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one set bit, or when pending==0.
  - out_zero = 1 when pending==0 at accept.
  - Handshake: on out_valid & out_ready at an edge:
    - if out_last, state <= IDLE and out_valid <= 0;
    - else the emitted bit is cleared in pending and the next index appears in the following cycle.
  - Sustained throughput is 1 index per cycle with out_ready held high.
  - Vector with N set bits: N beats, in_ready low for N cycles. All-zero vector: exactly 1 beat.
- Backpressure: while out_valid=1 and out_ready=0, bin_out, out_last and out_zero hold stable; pending is unchanged.
- in_valid while in_ready=0 is ignored; the upstream must hold its data until accepted.
- Width rules:
  - bin_out is exactly BIN_WIDTH bits.
  - Index 2**BIN_WIDTH-1 is legal; no wrap or overflow is possible.
  - Set-bit search is combinational over pending, registered into bin_out.
- No back-to-back overlap: a new vector is accepted no earlier than the cycle after the last beat handshakes. Minimum period per vector = N+1 cycles.

Optional Feature:
- Macro ENCODER_SEQ_MSB_FIRST_EN.
- Defined: the scan order is highest set bit first. bin_out = index of the highest set bit of pending; out_last = one remaining bit. All other behaviour is identical.
- Undefined (default): lowest set bit first, as above.

Test Plan:
- BIN_WIDTH=4, enc_in=16'h0008 accepted, out_ready=1 -> next cycle bin_out=3, out_last=1, out_zero=0; in_ready=1 the cycle after.
- enc_in=16'h8421, out_ready=1 -> beats 0,5,10,15 on consecutive cycles, out_last only on 15, in_ready low 4 cycles. With ENCODER_SEQ_MSB_FIRST_EN defined -> 15,10,5,0.
- enc_in=16'h0000 -> single beat bin_out=0, out_zero=1, out_last=1; then IDLE.
- enc_in=16'h0006, out_ready low 3 cycles after out_valid -> bin_out holds 1, out_valid stays 1; then beats 1, 2 with out_last on 2. in_valid pulses during EMIT are not accepted.
- enc_in=16'hFFFF, rst_n low at the edge after the 2nd beat handshake -> next cycle out_valid=0, bin_out=0, in_ready=1. A following enc_in=16'h0010 yields a single beat 4 with out_last=1.
- enc_in=16'hFFFF, out_ready=1 -> 16 beats 0..15 back-to-back, out_last only on 15; the next accept is possible exactly 1 cycle after.
